// File: rtl/scan_sequencer_pkg.sv
// Shared types and slot helpers for the scan sequencer.
package scan_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BLANK  = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    localparam logic [1:0] SLOT_FIRST_UP = 2'b00;
    localparam logic [1:0] SLOT_FIRST_DN = 2'b11;

    // First slot of a frame for the requested direction.
    function automatic logic [1:0] first_slot(input logic down);
        return down ? SLOT_FIRST_DN : SLOT_FIRST_UP;
    endfunction

    // Neighbouring slot; 2-bit arithmetic gives the 11<->00 wrap for free.
    function automatic logic [1:0] step_slot(input logic [1:0] s, input logic down);
        return down ? (s - 2'd1) : (s + 2'd1);
    endfunction

    // The terminal slot of a frame is the first slot of the opposite direction.
    function automatic logic is_terminal(input logic [1:0] s, input logic down);
        return s == (down ? SLOT_FIRST_UP : SLOT_FIRST_DN);
    endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and the sequencer.
interface scan_sequencer_if;
    logic       run;
    logic       dir;
    logic [1:0] sel;
    logic       en;
    logic       slot_start;
    logic       frame_done;
    logic       busy;

    modport master (
        output run, dir,
        input  sel, en, slot_start, frame_done, busy
    );

    modport slave (
        input  run, dir,
        output sel, en, slot_start, frame_done, busy
    );
endinterface

// File: rtl/scan_sequencer_slot_timer.sv
// Loadable down-counter timing one BLANK or ACTIVE phase.
// last flags the final cycle of the phase; last_next predicts it one cycle early
// so the parent can register pulses that line up with that final cycle.
module scan_sequencer_slot_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last,
    output logic          last_next
);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (count_reg != '0) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign last      = (count_reg == CW'(1));
    assign last_next = (count_next == CW'(1));

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed select generator for a 2-to-4 decoder: each slot is a
// blanking gap (en low) followed by a dwell (en high); slots step up or down.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int CW    = 8,
    parameter int DWELL = 8,
    parameter int BLANK = 2
) (
    input  logic              clk,
    input  logic              rst,
    scan_sequencer_if.slave   bus
);

    state_t        state_reg, state_next;
    logic [1:0]    sel_reg, sel_next;
    logic          dir_reg, dir_next;
    logic          en_reg, en_next;
    logic          slot_start_reg, slot_start_next;
    logic          frame_done_reg, frame_done_next;
    logic          busy_reg, busy_next;

    logic          timer_load;
    logic [CW-1:0] timer_load_val;
    logic          timer_last;
    logic          timer_last_next;

    scan_sequencer_slot_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_val  (timer_load_val),
        .last      (timer_last),
        .last_next (timer_last_next)
    );

    // State, slot/direction and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= SLOT_FIRST_UP;
            dir_reg        <= 1'b0;
            en_reg         <= 1'b0;
            slot_start_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            dir_reg        <= dir_next;
            en_reg         <= en_next;
            slot_start_reg <= slot_start_next;
            frame_done_reg <= frame_done_next;
            busy_reg       <= busy_next;
        end
    end

    // Next state, slot loading and phase timer control.
    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        dir_next       = dir_reg;
        timer_load     = 1'b0;
        timer_load_val = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.run) begin
                    sel_next   = first_slot(bus.dir);
                    dir_next   = bus.dir;
                    timer_load = 1'b1;
                    if (BLANK == 0) begin
                        state_next     = ST_ACTIVE;
                        timer_load_val = CW'(DWELL);
                    end else begin
                        state_next     = ST_BLANK;
                        timer_load_val = CW'(BLANK);
                    end
                end
            end
            ST_BLANK: begin
                // run is deliberately ignored: a started slot always completes.
                if (timer_last) begin
                    state_next     = ST_ACTIVE;
                    timer_load     = 1'b1;
                    timer_load_val = CW'(DWELL);
                end
            end
            ST_ACTIVE: begin
                if (timer_last) begin
                    if (bus.run) begin
                        sel_next   = step_slot(sel_reg, bus.dir);
                        dir_next   = bus.dir;
                        timer_load = 1'b1;
                        if (BLANK == 0) begin
                            state_next     = ST_ACTIVE;
                            timer_load_val = CW'(DWELL);
                        end else begin
                            state_next     = ST_BLANK;
                            timer_load_val = CW'(BLANK);
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the FSM is going.
    always_comb begin
        en_next         = (state_next == ST_ACTIVE);
        busy_next       = (state_next != ST_IDLE);
        // A fresh ACTIVE phase begins either from IDLE/BLANK or on a gapless reload.
        slot_start_next = (state_next == ST_ACTIVE) &&
                          ((state_reg != ST_ACTIVE) || timer_last);
        frame_done_next = (state_next == ST_ACTIVE) && timer_last_next &&
                          is_terminal(sel_next, dir_next);
    end

    assign bus.sel        = sel_reg;
    assign bus.en         = en_reg;
    assign bus.slot_start = slot_start_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench: three sequencer configurations share stimulus and are
// compared each cycle against a slot-position reference model.
module tb_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b1;
    logic dir = 1'b0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance configurations: 0 = (BLANK 1, DWELL 3), 1 = (0, 3), 2 = (2, 1).
    int cb [3] = '{1, 0, 2};
    int cd [3] = '{3, 3, 1};

    scan_sequencer_if ifa ();
    scan_sequencer_if ifb ();
    scan_sequencer_if ifc ();

    assign ifa.run = run;
    assign ifa.dir = dir;
    assign ifb.run = run;
    assign ifb.dir = dir;
    assign ifc.run = run;
    assign ifc.dir = dir;

    scan_sequencer #(.CW(8), .DWELL(3), .BLANK(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    scan_sequencer #(.CW(8), .DWELL(3), .BLANK(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    scan_sequencer #(.CW(4), .DWELL(1), .BLANK(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    // Downstream 2-to-4 decoders fed by each sequencer.
    logic [3:0] dec [3];
    assign dec[0] = ifa.en ? (4'b0001 << ifa.sel) : 4'b0000;
    assign dec[1] = ifb.en ? (4'b0001 << ifb.sel) : 4'b0000;
    assign dec[2] = ifc.en ? (4'b0001 << ifc.sel) : 4'b0000;

    // Observed vector: {sel, en, slot_start, frame_done, busy, D}.
    logic [9:0] obs [3];
    assign obs[0] = {ifa.sel, ifa.en, ifa.slot_start, ifa.frame_done, ifa.busy, dec[0]};
    assign obs[1] = {ifb.sel, ifb.en, ifb.slot_start, ifb.frame_done, ifb.busy, dec[1]};
    assign obs[2] = {ifc.sel, ifc.en, ifc.slot_start, ifc.frame_done, ifc.busy, dec[2]};

    // Reference model: idle flag, position inside the current slot (0-based,
    // blanking first), current slot and latched direction.
    bit         m_idle [3] = '{1'b1, 1'b1, 1'b1};
    int         m_pos  [3] = '{0, 0, 0};
    logic [1:0] m_sel  [3] = '{2'd0, 2'd0, 2'd0};
    logic       m_dir  [3] = '{1'b0, 1'b0, 1'b0};

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_idle[i] = 1'b1;
                m_pos[i]  = 0;
                m_sel[i]  = 2'd0;
                m_dir[i]  = 1'b0;
            end else if (m_idle[i]) begin
                if (run) begin
                    m_idle[i] = 1'b0;
                    m_pos[i]  = 0;
                    m_sel[i]  = dir ? 2'd3 : 2'd0;
                    m_dir[i]  = dir;
                end
            end else if (m_pos[i] == cb[i] + cd[i] - 1) begin
                if (run) begin
                    m_sel[i] = 2'((int'(m_sel[i]) + (dir ? 3 : 1)) % 4);
                    m_dir[i] = dir;
                    m_pos[i] = 0;
                end else begin
                    m_idle[i] = 1'b1;
                end
            end else begin
                m_pos[i] = m_pos[i] + 1;
            end
        end
    endtask

    function automatic logic [9:0] exp_vec(int i);
        logic b, e, ss, fd;
        logic [3:0] d;
        b  = !m_idle[i];
        e  = b && (m_pos[i] >= cb[i]);
        ss = b && (m_pos[i] == cb[i]);
        fd = b && (m_pos[i] == cb[i] + cd[i] - 1) && (m_sel[i] == (m_dir[i] ? 2'd0 : 2'd3));
        d  = e ? (4'b0001 << m_sel[i]) : 4'b0000;
        return {m_sel[i], e, ss, fd, b, d};
    endfunction

    // One clock: inputs stay stable across the edge, model follows, sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        run = 1'b0;
        dir = 1'b0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs[i] !== 10'b00_0_0_0_0_0000)
                $display("FAIL reset inst%0d got=%b want=%b", i, obs[i], 10'b0);
            else n_pass++;
        end
        rst = 1'b0;
        run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL idle_hold inst%0d cyc%0d got=%b want=%b", i, k, obs[i], exp_vec(i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_up_scan();
        logic [4:0] want;
        run = 1'b1;
        dir = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL up_scan inst%0d cyc%0d got=%b want=%b", i, n, obs[i], exp_vec(i));
                else n_pass++;
            end
            // Fixed timeline for BLANK=1, DWELL=3: {sel, en, slot_start, frame_done}.
            if (n == 1 || n == 2 || n == 5 || n == 14 || n == 16 || n == 17) begin
                case (n)
                    1:       want = 5'b00_0_0_0;
                    2:       want = 5'b00_1_1_0;
                    5:       want = 5'b01_0_0_0;
                    14:      want = 5'b11_1_1_0;
                    16:      want = 5'b11_1_0_1;
                    default: want = 5'b00_0_0_0;
                endcase
                n_checks++;
                if ({ifa.sel, ifa.en, ifa.slot_start, ifa.frame_done} !== want)
                    $display("FAIL up_timeline cyc%0d got=%b want=%b", n,
                             {ifa.sel, ifa.en, ifa.slot_start, ifa.frame_done}, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_gapless();
        logic [1:0] s;
        logic [9:0] want;
        int fd_count = 0;
        run = 1'b1;
        dir = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL gapless inst%0d cyc%0d got=%b want=%b", i, n, obs[i], exp_vec(i));
                else n_pass++;
            end
            s = 2'(((n - 1) / 3) % 4);
            want = {s, 1'b1, ((n - 1) % 3 == 0), (n % 12 == 0), 1'b1, 4'b0001 << s};
            if (ifb.frame_done) fd_count++;
            n_checks++;
            if (obs[1] !== want)
                $display("FAIL gapless_seq cyc%0d got=%b want=%b", n, obs[1], want);
            else n_pass++;
        end
        n_checks++;
        if (fd_count != 2)
            $display("FAIL gapless_frames got=%0d want=2", fd_count);
        else n_pass++;
    endtask

    task automatic test_down_flip();
        logic [4:0] want;
        run = 1'b1;
        dir = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL down_flip inst%0d cyc%0d got=%b want=%b", i, n, obs[i], exp_vec(i));
                else n_pass++;
            end
            if (n == 1 || n == 5 || n == 13 || n == 16 || n == 17 || n == 25) begin
                case (n)
                    1:       want = 5'b11_0_0_0;
                    5:       want = 5'b10_0_0_0;
                    13:      want = 5'b00_0_0_0;
                    16:      want = 5'b00_1_0_1;
                    17:      want = 5'b11_0_0_0;
                    default: want = 5'b11_0_0_0;
                endcase
                n_checks++;
                if ({ifa.sel, ifa.en, ifa.slot_start, ifa.frame_done} !== want)
                    $display("FAIL down_timeline cyc%0d got=%b want=%b", n,
                             {ifa.sel, ifa.en, ifa.slot_start, ifa.frame_done}, want);
                else n_pass++;
            end
            // Flip to up in the middle of the dwell of slot 10 (second frame).
            if (n == 22) dir = 1'b0;
        end
    endtask

    task automatic test_stop();
        run = 1'b1;
        dir = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL stop inst%0d cyc%0d got=%b want=%b", i, n, obs[i], exp_vec(i));
                else n_pass++;
            end
            if (n == 8) begin
                n_checks++;
                if ({ifa.sel, ifa.en, ifa.busy} !== 4'b01_1_1)
                    $display("FAIL stop_dwell got=%b want=%b", {ifa.sel, ifa.en, ifa.busy}, 4'b0111);
                else n_pass++;
            end
            if (n == 9 || n == 11) begin
                n_checks++;
                if ({ifa.sel, ifa.en, ifa.busy} !== 4'b01_0_0)
                    $display("FAIL stop_idle cyc%0d got=%b want=%b", n, {ifa.sel, ifa.en, ifa.busy}, 4'b0100);
                else n_pass++;
            end
            if (n == 12) begin
                n_checks++;
                if ({ifa.sel, ifa.en, ifa.busy} !== 4'b00_0_1)
                    $display("FAIL stop_restart got=%b want=%b", {ifa.sel, ifa.en, ifa.busy}, 4'b0001);
                else n_pass++;
            end
            if (n == 5) run = 1'b0;   // dropped during the blanking of slot 01
            if (n == 11) run = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        run = 1'b1;
        dir = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL reset_mid inst%0d cyc%0d got=%b want=%b", i, n, obs[i], exp_vec(i));
                else n_pass++;
            end
            if (n == 11) rst = 1'b1;  // second dwell cycle of slot 10
        end
        n_checks++;
        if ({ifa.sel, ifa.en, ifa.slot_start, ifa.frame_done, ifa.busy} !== 6'b00_0_0_0_0)
            $display("FAIL reset_mid_state got=%b want=%b",
                     {ifa.sel, ifa.en, ifa.slot_start, ifa.frame_done, ifa.busy}, 6'b0);
        else n_pass++;
        rst = 1'b0;
        test_up_scan();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            run = ($urandom_range(0, 9) < 8);
            dir = 1'($urandom_range(0, 1));
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL random inst%0d cyc%0d got=%b want=%b", i, n, obs[i], exp_vec(i));
                else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_scan();
        drain();
        test_gapless();
        drain();
        test_down_flip();
        drain();
        test_stop();
        drain();
        test_reset_mid();
        drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Time-multiplexed select generator that drives the 2-to-4 decoder's A[1:0] and E inputs.
Steps a 2-bit slot index through all four decoder outputs.
Holds each slot for a programmable dwell time, with a programmable blanking gap (decoder disabled) between slots to prevent ghosting on multiplexed display digits and keypad rows.
Signals slot and frame boundaries to downstream logic.

Parameters:
CW, 8, width of the internal slot timer
DWELL, 8, cycles the enable is high per slot; legal range 1..2^CW-1
BLANK, 2, cycles the enable is low before each slot; legal range 0..2^CW-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
run  in  1  1 = scanning requested; sampled in IDLE and on the last ACTIVE cycle of each slot
dir  in  1  0 = up (00→01→10→11), 1 = down (11→10→01→00); sampled only when a slot is loaded
sel  out  2  slot index; connects to decoder A[1:0]
en  out  1  decoder enable; connects to decoder E
slot_start  out  1  one-cycle pulse on the first ACTIVE cycle of each slot
frame_done  out  1  one-cycle pulse on the last ACTIVE cycle of the terminal slot
busy  out  1  1 whenever state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: sel=00, en=0, slot_start=0, frame_done=0, busy=0, state=IDLE, timer=0, dir_r=0.
- rst is sampled on clk. rst wins over every other input. Reset asserted mid-slot forces the reset values on the next cycle; the partial slot is abandoned.
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - en=0; sel holds its last value.
  - run=1 at cycle t → load slot: sel = 00 (dir=0) or 11 (dir=1), dir_r = dir.
  - Next state at t+1 is BLANK, or ACTIVE if BLANK=0.
- BLANK:
  - en=0; lasts exactly BLANK cycles, then ACTIVE.
  - run is ignored in BLANK; a started slot always completes.
- ACTIVE:
  - en=1 for exactly DWELL cycles.
  - slot_start=1 on the first ACTIVE cycle only.
- Last ACTIVE cycle:
  - If run=0, next state is IDLE, en=0, and sel holds.
  - If run=1, load the next slot: dir_r = dir; sel = sel+1 mod 4 if dir=0, sel-1 mod 4 if dir=1 (wrap 11→00 and 00→11).
  - Next state is BLANK, or ACTIVE if BLANK=0. With BLANK=0, en stays high continuously across slots.
- frame_done:
  - Asserted on the last ACTIVE cycle when (dir_r=0 and sel=11) or (dir_r=1 and sel=00).
  - Coincides with the final en=1 cycle; it can coincide with slot_start when DWELL=1.
- Timing:
  - Slot period = BLANK+DWELL cycles; frame period = 4*(BLANK+DWELL) cycles.
  - First en=1 occurs at t+1+BLANK after run is sampled.
- Direction change mid-slot takes effect at the next slot load only. sel never skips or repeats outside a dir change.
- en=1 only in ACTIVE; sel is stable for the whole BLANK+ACTIVE span of a slot.

Decomposition:
- Shared include (scan_defs.vh): state encodings IDLE=2'b00, BLANK=2'b01, ACTIVE=2'b10; slot constants SLOT_FIRST_UP=2'b00, SLOT_FIRST_DN=2'b11.
- One sub-module, slot_timer:
  - CW-bit loadable down-counter with inputs load and load_val.
  - Output last=1 when count==1.
  - Used for both the BLANK and ACTIVE phases.
- FSM, sel/dir_r registers and pulse generation live in scan_sequencer.
- The bench instantiates Decoder2x4 downstream and checks that D is one-hot when en=1 and all-zero when en=0.

Test Plan:
1. Reset and idle: rst=1 for 3 cycles with run=1 → sel=00, en=0, busy=0, both pulses 0; after release with run=0, outputs stay unchanged for 20 cycles.
2. Up scan, DWELL=3, BLANK=1, run=1 sampled at cycle 0:
   - Cycle 1: en=0, sel=00.
   - Cycles 2–4: en=1, sel=00, slot_start=1 at cycle 2.
   - Cycle 5: en=0, sel=01.
   - Cycles 14–16: sel=11, en=1, frame_done=1 at cycle 16.
   - Cycle 17: sel=00, en=0.
3. Gapless, BLANK=0, DWELL=3 → en high continuously; sel changes every 3 cycles (00,01,10,11,00); frame_done every 12 cycles; decoder D steps 0001→0010→0100→1000.
4. Down scan and direction flip: dir=1 → sel order 11,10,01,00, frame_done on the last cycle of 00. Toggle dir to 0 mid-ACTIVE of slot 10 → slot 10 completes and the next slot is 11.
5. Graceful stop: drop run during BLANK of slot 01 → slot 01 completes its full DWELL; then en=0, busy=0, sel=01 held. Re-assert run → restart at 00 (dir=0).
6. Reset mid-ACTIVE: rst=1 on the 2nd ACTIVE cycle of slot 10 → next cycle sel=00, en=0, busy=0, no frame_done; run=1 afterwards reproduces the scenario-2 timing exactly.
